render_cmd_sequencer: RTL

- Upstream feeder for the render Avalon-MM slave.
- Accepts packed draw commands on a valid/ready stream and buffers them in an internal FIFO.
- Converts each command into an ordered series of single-word Avalon writes to the renderer registers: texture (addr 4), x (addr 1), y (addr 2), plot trigger (addr 6).
- Replaces hand-written per-command write sequences with one reusable master.

---
 rtl/render_cmd_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/render_cmd_sequencer.sv
// Buffers packed draw commands in a small FIFO and replays each one as an ordered
// series of single-word Avalon-MM writes to the renderer register file.
`timescale 1ns/1ps
module render_cmd_sequencer #(
    parameter int DEPTH    = 8,
    parameter int X_MAX    = 319,
    parameter int Y_MAX    = 239,
    parameter int SKIP_TEX = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_bg,
    input  logic [6:0]               cmd_tex,
    input  logic [9:0]               cmd_x,
    input  logic [8:0]               cmd_y,
    output logic [3:0]               master_address,
    output logic                     master_write,
    output logic [31:0]              master_writedata,
    input  logic                     master_waitrequest,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     clamp_evt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 27;

    typedef enum logic [2:0] {IDLE, LOAD, WR_TEX, WR_X, WR_Y, WR_PLOT, GAP} state_t;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q, count_d;
    logic          ready_q;
    logic          clamp_q;
    logic          push, pop;
    logic          x_over, y_over;
    logic [9:0]    x_sat;
    logic [8:0]    y_sat;
    logic [EW-1:0] head;

    state_t        state_q, nxt_q;
    logic          wk_bg_q;
    logic [6:0]    wk_tex_q;
    logic [9:0]    wk_x_q;
    logic [8:0]    wk_y_q;
    logic [6:0]    cache_q;
    logic          cache_vld_q;
    logic [3:0]    addr_q;
    logic [31:0]   wdata_q;
    logic          write_q;

    logic          skip_tex;
    state_t        load_tgt, enter_tgt, follow;
    logic [3:0]    enter_addr;
    logic [31:0]   enter_data;

    // Coordinates are saturated on the way in so the FIFO only ever holds legal values.
    assign x_over = cmd_x > 10'(X_MAX);
    assign y_over = cmd_y > 9'(Y_MAX);
    assign x_sat  = x_over ? 10'(X_MAX) : cmd_x;
    assign y_sat  = y_over ? 9'(Y_MAX) : cmd_y;

    assign push = cmd_valid && ready_q;
    assign pop  = (state_q == IDLE) && (count_q != '0);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_bg, cmd_tex, x_sat, y_sat};
        end
    end

    // ready_q is the registered not-full flag, so a full FIFO refuses even with a same-cycle pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            clamp_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ready_q <= (count_d != LW'(DEPTH));
            clamp_q <= push && (x_over || y_over);
        end
    end

    assign skip_tex = (SKIP_TEX != 0) && cache_vld_q && (cache_q == wk_tex_q);

    always_comb begin
        load_tgt = WR_TEX;
        if (skip_tex) load_tgt = wk_bg_q ? WR_PLOT : WR_X;
        enter_tgt = (state_q == LOAD) ? load_tgt : nxt_q;

        enter_addr = 4'd0;
        enter_data = 32'd0;
        case (enter_tgt)
            WR_TEX:  begin enter_addr = 4'd4; enter_data = {25'd0, wk_tex_q}; end
            WR_X:    begin enter_addr = 4'd1; enter_data = {22'd0, wk_x_q};   end
            WR_Y:    begin enter_addr = 4'd2; enter_data = {23'd0, wk_y_q};   end
            WR_PLOT: begin enter_addr = 4'd6; enter_data = 32'd0;             end
            default: ;
        endcase

        follow = IDLE;
        case (state_q)
            WR_TEX:  follow = wk_bg_q ? WR_PLOT : WR_X;
            WR_X:    follow = WR_Y;
            WR_Y:    follow = WR_PLOT;
            default: follow = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            nxt_q       <= IDLE;
            wk_bg_q     <= 1'b0;
            wk_tex_q    <= '0;
            wk_x_q      <= '0;
            wk_y_q      <= '0;
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        {wk_bg_q, wk_tex_q, wk_x_q, wk_y_q} <= head;
                        state_q <= LOAD;
                    end
                end
                // Address/data are only loaded here, so they never move while write is high.
                LOAD, GAP: begin
                    state_q <= enter_tgt;
                    if (enter_tgt != IDLE) begin
                        write_q <= 1'b1;
                        addr_q  <= enter_addr;
                        wdata_q <= enter_data;
                    end
                end
                WR_TEX, WR_X, WR_Y, WR_PLOT: begin
                    if (!master_waitrequest) begin
                        write_q <= 1'b0;
                        state_q <= GAP;
                        nxt_q   <= follow;
                        if (state_q == WR_TEX) begin
                            cache_q     <= wk_tex_q;
                            cache_vld_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready        = ready_q;
    assign master_address   = addr_q;
    assign master_write     = write_q;
    assign master_writedata = wdata_q;
    assign busy             = (count_q != '0) || (state_q != IDLE);
    assign fifo_level       = count_q;
    assign clamp_evt        = clamp_q;

endmodule
